sm4_block_cipher_iter: RTL and testbench

- Parametrised, iterative SM4 (GB/T 32907) block-cipher core. Successor to the constant-only SM4 parameter set.
- Adds in-core key expansion with a stored round-key file, an encrypt/decrypt mode per block, and a configurable number of rounds unrolled per clock.
- Sits between the host key/data interfaces and downstream consumers. All three interfaces use valid/ready handshakes.

---
 rtl/sm4_block_cipher_iter_if.sv | 28 ++
 rtl/sm4_block_cipher_iter.sv | 181 ++++++++++++++++++
 tb/tb_sm4_block_cipher_iter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/sm4_block_cipher_iter_if.sv
// SM4 core host/consumer bundle: key load, block in, result out.
// Ports: key_v/key/key_ready/key_loaded, data_v/data/decrypt/data_ready, data_v_o/data_o/data_yumi.
interface sm4_block_cipher_iter_if #(
   parameter int group_size_p = 128,
   parameter int key_size_p   = group_size_p
);
   logic                    key_v_i;
   logic [key_size_p-1:0]   key_i;
   logic                    key_ready_o;
   logic                    key_loaded_o;
   logic                    data_v_i;
   logic [group_size_p-1:0] data_i;
   logic                    decrypt_i;
   logic                    data_ready_o;
   logic                    data_v_o;
   logic [group_size_p-1:0] data_o;
   logic                    data_yumi_i;

   modport slave (
      input  key_v_i, key_i, data_v_i, data_i, decrypt_i, data_yumi_i,
      output key_ready_o, key_loaded_o, data_ready_o, data_v_o, data_o
   );

   modport master (
      output key_v_i, key_i, data_v_i, data_i, decrypt_i, data_yumi_i,
      input  key_ready_o, key_loaded_o, data_ready_o, data_v_o, data_o
   );
endinterface

// File: rtl/sm4_block_cipher_iter.sv
// Iterative SM4 core: in-core key expansion into a 32-entry round-key file,
// per-block encrypt/decrypt, rounds_per_cycle_p rounds per clock.
// Ports: clk_i, reset_n_i (sync, active low), sm4_io (slave side of the bundle).
module sm4_block_cipher_iter #(
   parameter int word_width_p       = 32,
   parameter int group_size_p       = 128,
   parameter int key_size_p         = group_size_p,
   parameter int rounds_per_cycle_p = 1
) (
   input  logic                           clk_i,
   input  logic                           reset_n_i,
   sm4_block_cipher_iter_if.slave         sm4_io
);
   localparam int W = word_width_p;
   localparam int R = rounds_per_cycle_p;
   localparam logic [4:0] LAST = 5'(32 - R);
   localparam logic [127:0] FK = 128'hA3B1BAC656AA3350677D9197B27022DC;

   localparam logic [2047:0] SBOX = {
      128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
      128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
      128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
      128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
      128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
      128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
      128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
      128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
   };

   typedef enum logic [2:0] {IDLE, KEYEXP, READY, BUSY, DONE} state_e;

   function automatic logic [W-1:0] rol(input logic [W-1:0] b, input int n);
      return (b << n) | (b >> (W - n));
   endfunction

   function automatic logic [W-1:0] tau(input logic [W-1:0] a);
      logic [W-1:0] t;
      for (int j = 0; j < 4; j++) t[8*j +: 8] = SBOX[{~a[8*j +: 8], 3'b000} +: 8];
      return t;
   endfunction

   function automatic logic [W-1:0] t_key(input logic [W-1:0] a);
      logic [W-1:0] b;
      b = tau(a);
      return b ^ rol(b, 13) ^ rol(b, 23);
   endfunction

   function automatic logic [W-1:0] t_enc(input logic [W-1:0] a);
      logic [W-1:0] b;
      b = tau(a);
      return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
   endfunction

   // CK_i byte j = (4i+j)*7 mod 256, byte 0 in the MSBs
   function automatic logic [W-1:0] ck_f(input logic [4:0] i);
      logic [W-1:0] c;
      c = '0;
      for (int j = 0; j < 4; j++) c[W-1-8*j -: 8] = 8'(({i, 2'b00} + 7'(j)) * 7);
      return c;
   endfunction

   state_e state_q, state_d;
   logic [4:0]              cnt_q;
   logic                    loaded_q;
   logic                    dec_q;
   logic [key_size_p-1:0]   k_q;
   logic [group_size_p-1:0] x_q;
   logic [W-1:0]            rkf_q [32];

   logic [W-1:0] kc   [R+4];
   logic [W-1:0] xc   [R+4];
   logic [W-1:0] rk_w [R];
   logic [4:0]   ridx [R];
   logic         last;

   assign last = (cnt_q == LAST);

   // Unrolled key-schedule and cipher round chains sharing the round index
   always_comb begin
      kc   = '{default: '0};
      xc   = '{default: '0};
      rk_w = '{default: '0};
      ridx = '{default: '0};
      for (int i = 0; i < 4; i++) begin
         kc[i] = k_q[127-32*i -: 32];
         xc[i] = x_q[127-32*i -: 32];
      end
      for (int r = 0; r < R; r++) begin
         ridx[r]   = cnt_q + 5'(r);
         kc[r+4]   = kc[r] ^ t_key(kc[r+1] ^ kc[r+2] ^ kc[r+3] ^ ck_f(ridx[r]));
         rk_w[r]   = kc[r+4];
         xc[r+4]   = xc[r] ^ t_enc(xc[r+1] ^ xc[r+2] ^ xc[r+3] ^
                     rkf_q[dec_q ? ~ridx[r] : ridx[r]]);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) state_q <= IDLE;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (sm4_io.key_v_i) state_d = KEYEXP;
         KEYEXP:  if (last) state_d = READY;
         READY: begin
            if (sm4_io.key_v_i)       state_d = KEYEXP;
            else if (sm4_io.data_v_i) state_d = BUSY;
         end
         BUSY:    if (last) state_d = DONE;
         DONE:    if (sm4_io.data_yumi_i) state_d = READY;
         default: state_d = IDLE;
      endcase
   end

   logic                    key_ready, data_ready, data_v;
   logic [group_size_p-1:0] data_out;

   always_comb begin
      key_ready  = (state_q == IDLE) || (state_q == READY);
      data_ready = (state_q == READY);
      data_v     = (state_q == DONE);
      data_out   = data_v ? x_q : '0;
   end

   assign sm4_io.key_ready_o  = key_ready;
   assign sm4_io.key_loaded_o = loaded_q;
   assign sm4_io.data_ready_o = data_ready;
   assign sm4_io.data_v_o     = data_v;
   assign sm4_io.data_o       = data_out;

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         cnt_q    <= '0;
         loaded_q <= 1'b0;
         dec_q    <= 1'b0;
         k_q      <= '0;
         x_q      <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (sm4_io.key_v_i) begin
                  k_q   <= sm4_io.key_i ^ FK;
                  cnt_q <= '0;
               end
            end
            KEYEXP: begin
               k_q   <= {kc[R], kc[R+1], kc[R+2], kc[R+3]};
               cnt_q <= cnt_q + 5'(R);
               if (last) loaded_q <= 1'b1;
            end
            READY: begin
               if (sm4_io.key_v_i) begin
                  k_q      <= sm4_io.key_i ^ FK;
                  cnt_q    <= '0;
                  loaded_q <= 1'b0;
               end else if (sm4_io.data_v_i) begin
                  x_q   <= sm4_io.data_i;
                  dec_q <= sm4_io.decrypt_i;
                  cnt_q <= '0;
               end
            end
            BUSY: begin
               cnt_q <= cnt_q + 5'(R);
               // final cycle stores the reversed word order Y0..Y3
               if (last) x_q <= {xc[R+3], xc[R+2], xc[R+1], xc[R]};
               else      x_q <= {xc[R], xc[R+1], xc[R+2], xc[R+3]};
            end
            DONE:    ;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_n_i && state_q == KEYEXP) begin
         for (int r = 0; r < R; r++) rkf_q[ridx[r]] <= rk_w[r];
      end
   end
endmodule

// File: tb/tb_sm4_block_cipher_iter.sv
// Directed bench for sm4_block_cipher_iter at rounds_per_cycle_p = 1, 4, 32.
// All three cores share one stimulus stream; results checked against constants and a model.
module tb_sm4_block_cipher_iter;
   logic         clk, rst_n;
   logic         key_v, data_v, dec, yumi;
   logic [127:0] key, data;
   logic [2:0]   kl, dvo, drdy, krdy;
   logic [127:0] dout [3];

   int           pass_cnt, total_cnt;
   int           lat  [3];
   logic [127:0] res  [3];
   logic         any_dv;
   logic [127:0] exp0;

   localparam logic [127:0] K1 = 128'h0123456789ABCDEFFEDCBA9876543210;
   localparam logic [127:0] P1 = 128'h0123456789ABCDEFFEDCBA9876543210;
   localparam logic [127:0] C1 = 128'h681EDF34D206965E86B3E94F536E4246;

   logic [2047:0] sb_tab = {
      128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
      128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
      128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
      128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
      128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
      128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
      128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
      128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
   };

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int RG = (g == 0) ? 1 : (g == 1) ? 4 : 32;
      sm4_block_cipher_iter_if bus ();
      assign bus.key_v_i     = key_v;
      assign bus.key_i       = key;
      assign bus.data_v_i    = data_v;
      assign bus.data_i      = data;
      assign bus.decrypt_i   = dec;
      assign bus.data_yumi_i = yumi;
      assign kl[g]   = bus.key_loaded_o;
      assign dvo[g]  = bus.data_v_o;
      assign drdy[g] = bus.data_ready_o;
      assign krdy[g] = bus.key_ready_o;
      assign dout[g] = bus.data_o;
      sm4_block_cipher_iter #(.rounds_per_cycle_p(RG)) dut (
         .clk_i     (clk),
         .reset_n_i (rst_n),
         .sm4_io    (bus)
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rol(input logic [31:0] v, input int n);
      return (v << n) | (v >> (32 - n));
   endfunction

   function automatic logic [31:0] tsb(input logic [31:0] a);
      logic [31:0] r;
      for (int j = 0; j < 4; j++) r[8*j +: 8] = sb_tab[2047 - 8*int'(a[8*j +: 8]) -: 8];
      return r;
   endfunction

   function automatic logic [127:0] sm4_model(input logic [127:0] mk,
                                              input logic [127:0] blk,
                                              input logic d);
      logic [31:0]  k [36];
      logic [31:0]  rk [32];
      logic [31:0]  x [36];
      logic [31:0]  t, c;
      logic [127:0] fk;
      fk = 128'hA3B1BAC656AA3350677D9197B27022DC;
      for (int i = 0; i < 4; i++) begin
         k[i] = mk[127-32*i -: 32] ^ fk[127-32*i -: 32];
         x[i] = blk[127-32*i -: 32];
      end
      for (int i = 0; i < 32; i++) begin
         for (int j = 0; j < 4; j++) c[31-8*j -: 8] = 8'(((4*i + j) * 7) % 256);
         t = tsb(k[i+1] ^ k[i+2] ^ k[i+3] ^ c);
         k[i+4] = k[i] ^ t ^ rol(t, 13) ^ rol(t, 23);
         rk[i] = k[i+4];
      end
      for (int i = 0; i < 32; i++) begin
         t = tsb(x[i+1] ^ x[i+2] ^ x[i+3] ^ (d ? rk[31-i] : rk[i]));
         x[i+4] = x[i] ^ t ^ rol(t, 2) ^ rol(t, 10) ^ rol(t, 18) ^ rol(t, 24);
      end
      return {x[35], x[34], x[33], x[32]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      total_cnt++;
      assert (obs === expv) pass_cnt++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
   endtask

   // up to 40 cycles: first cycle each core shows key_loaded_o (use_kl) or data_v_o
   task automatic wait_rise(input logic use_kl);
      any_dv = 1'b0;
      for (int k = 0; k < 3; k++) begin
         lat[k] = 0;
         res[k] = '0;
      end
      for (int n = 1; n <= 40; n++) begin
         step();
         any_dv = any_dv | (|dvo);
         for (int k = 0; k < 3; k++) begin
            if ((use_kl ? kl[k] : dvo[k]) && lat[k] == 0) begin
               lat[k] = n;
               res[k] = dout[k];
            end
         end
      end
   endtask

   task automatic chk_lat(input string tag);
      chk({tag, "_lat_r1"},  128'(lat[0]), 128'd32);
      chk({tag, "_lat_r4"},  128'(lat[1]), 128'd8);
      chk({tag, "_lat_r32"}, 128'(lat[2]), 128'd1);
   endtask

   task automatic chk_res(input string tag, input logic [127:0] expv);
      chk({tag, "_r1"},  res[0], expv);
      chk({tag, "_r4"},  res[1], expv);
      chk({tag, "_r32"}, res[2], expv);
   endtask

   task automatic yumi_pulse();
      yumi = 1'b1;
      step();
      yumi = 1'b0;
   endtask

   initial begin
      pass_cnt = 0; total_cnt = 0;
      rst_n = 1'b0; key_v = 1'b0; data_v = 1'b0; dec = 1'b0; yumi = 1'b0;
      key = '0; data = '0;
      step(); step();
      chk("rst_key_ready",  128'(krdy), 128'h7);
      chk("rst_data_ready", 128'(drdy), 128'h0);
      chk("rst_data_v",     128'(dvo),  128'h0);
      chk("rst_key_loaded", 128'(kl),   128'h0);
      chk("rst_data_o",     dout[0] | dout[1] | dout[2], 128'h0);
      rst_n = 1'b1;

      key = K1; key_v = 1'b1;
      step();
      key_v = 1'b0;
      chk("kexp_loaded_low", 128'(kl), 128'h0);
      wait_rise(1'b1);
      chk_lat("keyexp");
      chk("rk0",  128'(g_dut[0].dut.rkf_q[0]),  128'hF12186F9);
      chk("rk31", 128'(g_dut[0].dut.rkf_q[31]), 128'h9124A012);
      chk("ready_after_key", 128'(drdy), 128'h7);

      data = P1; dec = 1'b0; data_v = 1'b1;
      step();
      data_v = 1'b0;
      wait_rise(1'b0);
      chk_lat("enc");
      chk_res("enc_data", C1);

      data = C1; data_v = 1'b1; key_v = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         chk("hold_flags", 128'({dvo, drdy, krdy}), 128'h1C0);
         chk("hold_data", dout[0] ^ dout[1] ^ dout[2], C1);
      end
      data_v = 1'b0;
      yumi_pulse();
      chk("yumi_data_v", 128'(dvo),  128'h0);
      chk("yumi_data_o", dout[0] | dout[1] | dout[2], 128'h0);
      chk("yumi_ready",  128'(drdy), 128'h7);
      step(); step(); step();
      chk("no_extra_block", 128'(dvo), 128'h0);

      data = C1; dec = 1'b1; data_v = 1'b1;
      step();
      data_v = 1'b0; dec = 1'b0;
      wait_rise(1'b0);
      chk_lat("dec");
      chk_res("dec_data", P1);
      yumi_pulse();

      key = '0; key_v = 1'b1; data = P1; data_v = 1'b1;
      step();
      key_v = 1'b0; data_v = 1'b0;
      chk("both_loaded_low", 128'(kl),   128'h0);
      chk("both_ready_low",  128'(drdy), 128'h0);
      wait_rise(1'b1);
      chk_lat("rekey");
      chk("dropped_block", 128'(any_dv), 128'h0);

      exp0 = sm4_model(128'h0, 128'h0, 1'b0);
      data = '0; data_v = 1'b1;
      step();
      data_v = 1'b0;
      wait_rise(1'b0);
      chk_res("zero_enc", exp0);
      yumi_pulse();

      data = P1; data_v = 1'b1;
      step();
      data_v = 1'b0;
      repeat (9) step();
      rst_n = 1'b0;
      step();
      chk("mid_rst_key_ready",  128'(krdy), 128'h7);
      chk("mid_rst_loaded",     128'(kl),   128'h0);
      chk("mid_rst_data_ready", 128'(drdy), 128'h0);
      chk("mid_rst_data_v",     128'(dvo),  128'h0);
      chk("mid_rst_data_o",     dout[0] | dout[1] | dout[2], 128'h0);
      rst_n = 1'b1;
      wait_rise(1'b0);
      chk("mid_rst_no_pulse",   128'(any_dv), 128'h0);
      chk("mid_rst_still_unld", 128'(kl),     128'h0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
